// File: rtl/imm_gen.sv
// RV32I immediate generator: classifies the instruction format from the opcode
// and registers the sign-extended immediate, a format tag and a valid flag.
module imm_gen #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] imm_ext,
  output logic [2:0]      imm_type,
  output logic            imm_valid
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [2:0] TYPE_NONE = 3'd0;
  localparam logic [2:0] TYPE_I    = 3'd1;
  localparam logic [2:0] TYPE_S    = 3'd2;
  localparam logic [2:0] TYPE_B    = 3'd3;
  localparam logic [2:0] TYPE_U    = 3'd4;
  localparam logic [2:0] TYPE_J    = 3'd5;

  logic [6:0]  opcode;
  logic        sign;
  logic [31:0] imm_next;
  logic [2:0]  type_next;

  assign opcode = instruction[6:0];
  assign sign   = instruction[31];

  // funct3 is deliberately ignored: shift-immediates decode as plain I-type.
  always_comb begin
    imm_next  = '0;
    type_next = TYPE_NONE;
    unique case (opcode)
      OP_LUI, OP_AUIPC: begin
        imm_next  = {instruction[31:12], 12'b0};
        type_next = TYPE_U;
      end
      OP_JAL: begin
        imm_next  = {{12{sign}}, instruction[19:12], instruction[20],
                     instruction[30:21], 1'b0};
        type_next = TYPE_J;
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        imm_next  = {{21{sign}}, instruction[30:20]};
        type_next = TYPE_I;
      end
      OP_BRANCH: begin
        imm_next  = {{20{sign}}, instruction[7], instruction[30:25],
                     instruction[11:8], 1'b0};
        type_next = TYPE_B;
      end
      OP_STORE: begin
        imm_next  = {{21{sign}}, instruction[30:25], instruction[11:7]};
        type_next = TYPE_S;
      end
      default: begin
        imm_next  = '0;
        type_next = TYPE_NONE;
      end
    endcase
  end

  // Data registers load every edge; imm_valid alone qualifies them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_ext   <= '0;
      imm_type  <= TYPE_NONE;
      imm_valid <= 1'b0;
    end else begin
      imm_ext   <= imm_next;
      imm_type  <= type_next;
      imm_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_imm_gen.sv
// Scoreboard bench for imm_gen: a driver pushes expected results, a monitor
// pops and compares one edge later; random traffic uses an arithmetic model.
module tb_imm_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instruction;
  logic [31:0] imm_ext;
  logic [2:0]  imm_type;
  logic        imm_valid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  t;
    logic        v;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  imm_gen #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
    .imm_ext(imm_ext), .imm_type(imm_type), .imm_valid(imm_valid)
  );

  always #5 clk = ~clk;

  // Reference: immediates built with arithmetic shifts and masks on signed values.
  function automatic void ref_model(input logic [31:0] ins,
                                    output logic [31:0] imm, output logic [2:0] t);
    logic signed [31:0] s;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    s = $signed(ins);
    imm = 32'd0;
    t = 3'd0;
    case (ins[6:0])
      7'h37, 7'h17: begin imm = ins & 32'hFFFF_F000; t = 3'd4; end
      7'h6F: begin
        j21 = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        imm = 32'(j21); t = 3'd5;
      end
      7'h67, 7'h03, 7'h13: begin imm = 32'(s >>> 20); t = 3'd1; end
      7'h63: begin
        b13 = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        imm = 32'(b13); t = 3'd3;
      end
      7'h23: begin
        imm = (32'(s >>> 20) & 32'hFFFF_FFE0) | 32'(ins[11:7]); t = 3'd2;
      end
      default: begin imm = 32'd0; t = 3'd0; end
    endcase
  endfunction

  task automatic send(input logic [31:0] ins, input logic v,
                      input logic [31:0] eimm, input logic [2:0] et, input string nm);
    exp_t e;
    @(negedge clk);
    instruction = ins;
    in_valid    = v;
    e.imm = eimm; e.t = et; e.v = v;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic send_rand(input logic [31:0] ins, input logic v, input string nm);
    logic [31:0] eimm;
    logic [2:0]  et;
    ref_model(ins, eimm, et);
    send(ins, v, eimm, et, nm);
  endtask

  task automatic check_now(input string nm, input logic [31:0] eimm,
                           input logic [2:0] et, input logic ev);
    checks++;
    if (imm_ext !== eimm || imm_type !== et || imm_valid !== ev) begin
      errors++;
      $display("FAIL %s: got imm=%h type=%0d valid=%0d, expected imm=%h type=%0d valid=%0d",
               nm, imm_ext, imm_type, imm_valid, eimm, et, ev);
    end
  endtask

  // Monitor: each edge without reset presents the result of the previous push.
  always @(posedge clk) begin
    exp_t  e;
    string nm;
    #1;
    if (!rst && exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check_now(nm, e.imm, e.t, e.v);
      $display("txn %-10s imm=%h type=%0d valid=%0d", nm, imm_ext, imm_type, imm_valid);
    end
  end

  localparam logic [6:0] OPS [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03,
                                      7'h13, 7'h63, 7'h23, 7'h33, 7'h73};

  initial begin
    logic [31:0] r;
    rst = 1'b1;
    in_valid = 1'b0;
    instruction = 32'h0;
    #2;
    check_now("reset", 32'h0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-derived expectations, back to back.
    send(32'h80184037, 1'b1, 32'h80184000, 3'd4, "lui");
    send(32'h80084017, 1'b1, 32'h80084000, 3'd4, "auipc");
    send(32'hFFFFF06F, 1'b1, 32'hFFFFFFFE, 3'd5, "jal");
    send(32'h80000067, 1'b1, 32'hFFFFF800, 3'd1, "jalr");
    send(32'h820008A3, 1'b1, 32'hFFFFF831, 3'd2, "store");
    send(32'h00109003, 1'b0, 32'h00000001, 3'd1, "load_inv");
    send(32'h00109013, 1'b1, 32'h00000001, 3'd1, "opimm");
    send(32'h00208033, 1'b1, 32'h00000000, 3'd0, "op");
    send(32'h00000073, 1'b1, 32'h00000000, 3'd0, "system");
    send(32'h820008E3, 1'b1, 32'hFFFFF830, 3'd3, "branch");

    // Async reset while the branch result is held, then release mid-stream.
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_now("rst_async", 32'h0, 3'd0, 1'b0);
    @(negedge clk);
    instruction = 32'h80184037;
    in_valid = 1'b1;
    @(posedge clk);
    #1 check_now("rst_hold", 32'h0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    begin
      exp_t e;
      e.imm = 32'h80184000; e.t = 3'd4; e.v = 1'b1;
      exp_q.push_back(e);
      name_q.push_back("post_rst");
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      if ($urandom_range(0, 9) != 0) r[6:0] = OPS[$urandom_range(0, 9)];
      send_rand(r, 1'($urandom_range(0, 3) != 0), "random");
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
